// File: rtl/addrc_controller.sv
// Control FSM for the add-round-constant pass: sequences LOAD/XOR/WRITE over 64 slices and tracks the round index.
// Optional build macro ADDRC_CTRL_PERF_EN adds the pass_cycles performance output.
module addrc_controller #(
  parameter int ROUNDS = 24,
  parameter int RIDX_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cnt_co_64,
  output logic              busy,
  output logic              done,
  output logic              cnt_rst_64,
  output logic              cnt_en_64,
  output logic              inreg_en,
  output logic              xor_en,
  output logic              mem_wr_en,
  output logic [RIDX_W-1:0] round_idx,
  output logic              last_round
`ifdef ADDRC_CTRL_PERF_EN
  ,
  output logic [8:0]        pass_cycles
`endif
);

  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(ROUNDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_XOR   = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Moore strobe decode; unused encodings fall back to IDLE.
  always_comb begin
    state_next = ST_IDLE;
    busy       = 1'b0;
    done       = 1'b0;
    cnt_rst_64 = 1'b0;
    cnt_en_64  = 1'b0;
    inreg_en   = 1'b0;
    xor_en     = 1'b0;
    mem_wr_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next = start ? ST_INIT : ST_IDLE;
      end
      ST_INIT: begin
        busy       = 1'b1;
        cnt_rst_64 = 1'b1;
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        busy       = 1'b1;
        inreg_en   = 1'b1;
        state_next = ST_XOR;
      end
      ST_XOR: begin
        busy       = 1'b1;
        xor_en     = 1'b1;
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        busy       = 1'b1;
        xor_en     = 1'b1;
        mem_wr_en  = 1'b1;
        cnt_en_64  = 1'b1;
        state_next = cnt_co_64 ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The round index advances once per completed pass and wraps after the final round.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_idx <= '0;
    end else if (state == ST_DONE) begin
      round_idx <= (round_idx == LAST_IDX) ? '0 : round_idx + 1'b1;
    end
  end

  assign last_round = (round_idx == LAST_IDX);

`ifdef ADDRC_CTRL_PERF_EN
  logic [8:0] perf_cnt;

  // Counter restarts when INIT is entered, so DONE observes INIT + 192 slice cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt    <= '0;
      pass_cycles <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        perf_cnt <= '0;
      end else if (busy) begin
        perf_cnt <= perf_cnt + 9'd1;
      end
      if (state == ST_DONE) begin
        pass_cycles <= perf_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_addrc_controller.sv
// Randomized scoreboard bench for addrc_controller with a slice-counter model driving cnt_co_64.
`timescale 1ns/1ps
module tb_addrc_controller;

  localparam int ROUNDS = 24;
  localparam int RIDX_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              cnt_co_64;
  logic              busy;
  logic              done;
  logic              cnt_rst_64;
  logic              cnt_en_64;
  logic              inreg_en;
  logic              xor_en;
  logic              mem_wr_en;
  logic [RIDX_W-1:0] round_idx;
  logic              last_round;
`ifdef ADDRC_CTRL_PERF_EN
  logic [8:0]        pass_cycles;
`endif

  addrc_controller #(.ROUNDS(ROUNDS), .RIDX_W(RIDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cnt_co_64  (cnt_co_64),
    .busy       (busy),
    .done       (done),
    .cnt_rst_64 (cnt_rst_64),
    .cnt_en_64  (cnt_en_64),
    .inreg_en   (inreg_en),
    .xor_en     (xor_en),
    .mem_wr_en  (mem_wr_en),
    .round_idx  (round_idx),
    .last_round (last_round)
`ifdef ADDRC_CTRL_PERF_EN
    ,
    .pass_cycles(pass_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Datapath slice counter as seen by the controller: cleared by cnt_rst_64, 6-bit wrap on cnt_en_64.
  bit [5:0] dp_cnt = 6'd0;
  always @(posedge clk) begin
    if (cnt_rst_64 === 1'b1) dp_cnt <= 6'd0;
    else if (cnt_en_64 === 1'b1) dp_cnt <= dp_cnt + 6'd1;
  end
  assign cnt_co_64 = (dp_cnt == 6'd63);

  typedef struct {
    int done_edge;
    int round;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  bit pass_active = 1'b0;
  int pass_start = 0;
  int model_round = 0;
  int model_pc = 0;
  bit model_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at edge %0d", name, actual, expected, edge_cnt);
    end
  endtask

  // Reference model: a pass accepted at edge N is busy for offsets 0..193 after N,
  // with one INIT cycle, 64 LOAD/XOR/WRITE triples, then DONE.
  task automatic applyStimulus(input bit s, input bit r);
    @(negedge clk);
    start = s;
    rst   = r;
    @(posedge clk);
    edge_cnt++;
    if (r) begin
      pass_active = 1'b0;
      model_round = 0;
      model_pc    = 0;
      model_valid = 1'b1;
      sb.delete();
    end else if (pass_active) begin
      if (edge_cnt == pass_start + 194) begin
        pass_active = 1'b0;
        model_round = (model_round + 1) % ROUNDS;
        model_pc    = 193;
      end
    end else if (s && model_valid) begin
      pass_active = 1'b1;
      pass_start  = edge_cnt;
      sb.push_back('{done_edge: edge_cnt + 193, round: model_round});
    end
  endtask

  // Expected {cnt_rst_64, inreg_en, xor_en, mem_wr_en, cnt_en_64, done} at pass offset k.
  function automatic logic [5:0] expStrobes(input bit active, input int k);
    if (!active) return 6'b000000;
    if (k == 0) return 6'b100000;
    if (k == 193) return 6'b000001;
    case ((k - 1) % 3)
      0:       return 6'b010000;
      1:       return 6'b001000;
      default: return 6'b001110;
    endcase
  endfunction

  logic [5:0] exp_s;
  logic [5:0] act_s;
  exp_t       item;

  // Monitor: per-cycle strobe/status check plus scoreboard pop whenever done is presented.
  always @(negedge clk) begin
    if (model_valid) begin
      exp_s = expStrobes(pass_active, edge_cnt - pass_start);
      act_s = {cnt_rst_64, inreg_en, xor_en, mem_wr_en, cnt_en_64, done};
      checkOutput("strobes", 32'(act_s), 32'(exp_s));
      checkOutput("busy", 32'(busy), 32'(pass_active));
      checkOutput("round_idx", 32'(round_idx), model_round);
      checkOutput("last_round", 32'(last_round), 32'(model_round == ROUNDS - 1));
`ifdef ADDRC_CTRL_PERF_EN
      checkOutput("pass_cycles", 32'(pass_cycles), model_pc);
`endif
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("done_unexpected", 32'(done), 32'd0);
        end else begin
          item = sb.pop_front();
          checkOutput("done_edge", edge_cnt, item.done_edge);
          checkOutput("done_round", 32'(round_idx), item.round);
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;

    repeat (2) applyStimulus(1'b0, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b0);

    // Single isolated pass.
    applyStimulus(1'b1, 1'b0);
    repeat (200) applyStimulus(1'b0, 1'b0);

    // Start re-asserted at offsets 5 and 100 of a running pass must be ignored.
    applyStimulus(1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (94) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (100) applyStimulus(1'b0, 1'b0);

    // Start held high: back-to-back passes, enough to wrap the round index.
    repeat (25 * 195) applyStimulus(1'b1, 1'b0);
    repeat (200) applyStimulus(1'b0, 1'b0);

    // Reset during WRITE of slice 30, then a fresh full pass.
    applyStimulus(1'b1, 1'b0);
    repeat (93) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    repeat (200) applyStimulus(1'b0, 1'b0);

    // Random start pulses with rare resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 511) == 0);
    end
    repeat (200) applyStimulus(1'b0, 1'b0);

    checkOutput("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addrc_controller.md
Name: addrc_controller

Overview:
- FSM that sequences the add-round-constant (addRC) datapath over the 64 slices of the state memory.
- For each slice it loads the input register, enables the XOR and writes the result back, stepping the datapath's 6-bit slice counter.
- Tracks the permutation round index and handshakes with the top-level round scheduler through start/done.

Parameters:
- ROUNDS, 24, number of rounds per permutation; round_idx wraps after ROUNDS-1.
- RIDX_W, 5, width of round_idx; must satisfy 2^RIDX_W >= ROUNDS.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request one addRC pass; sampled only in IDLE.
- cnt_co_64  input  1  carry-out from datapath slice counter; high while count == 63.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a pass completes.
- cnt_rst_64  output  1  synchronous clear of datapath slice counter.
- cnt_en_64  output  1  slice counter increment enable.
- inreg_en  output  1  load datapath input register from mem_line.
- xor_en  output  1  enable round-constant XOR in addRC.
- mem_wr_en  output  1  write write_value back to memory line cnt_value.
- round_idx  output  RIDX_W  current round number, used for round-constant selection.
- last_round  output  1  high when round_idx == ROUNDS-1.

Behaviour:
- States: IDLE, INIT, LOAD, XOR, WRITE, DONE. All control outputs are Moore, decoded from state.
- Reset (rst=1 at a clock edge, from any state):
  - state goes to IDLE; round_idx is cleared to 0.
  - All outputs are 0, except last_round, which is (ROUNDS==1).
  - Reset mid-pass abandons the pass with no done pulse; the datapath counter is cleared at the next INIT.
- IDLE: all strobes 0. start=1 goes to INIT; otherwise stay in IDLE.
- INIT: cnt_rst_64=1 for one cycle, then LOAD.
- LOAD: inreg_en=1, then XOR.
- XOR: xor_en=1, then WRITE.
- WRITE:
  - mem_wr_en=1, xor_en=1 (held so write_value stays valid), cnt_en_64=1.
  - If cnt_co_64=1, go to DONE; otherwise go to LOAD.
- DONE:
  - done=1 for exactly one cycle.
  - round_idx increments on this edge; if round_idx == ROUNDS-1 it wraps to 0.
  - Next state is IDLE.
- Latency: start sampled in IDLE at edge N; done is high in cycle N+1+1+3*64 = N+194. busy is high for 194 cycles (INIT 1 + 192 slice cycles + DONE 1).
- Slice counter wrap: the cnt_en_64 pulse in the final WRITE (count 63) wraps the datapath counter to 0. This is harmless because INIT clears it again.
- start while busy is ignored, not queued. start held high continuously gives back-to-back passes with one IDLE cycle between them.
- busy=1 in INIT, LOAD, XOR, WRITE and DONE.
- cnt_co_64 is evaluated only in WRITE; its value in other states is don't-care.
- Unused state encodings go to IDLE on the next edge.

Optional Feature:
- Macro ADDRC_CTRL_PERF_EN.
- When defined: adds output pass_cycles [8:0].
  - A free counter clears on entry to INIT and increments every busy cycle.
  - Its value is latched into pass_cycles in DONE; a normal pass latches 193.
  - Reset clears both the counter and pass_cycles.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst high 2 cycles, then start=0 for 10 cycles -> busy=0, done=0, all strobes 0, round_idx=0, last_round=0.
- Single pass with a counter model driving cnt_co_64 at count 63:
  - pulse start for 1 cycle -> cnt_rst_64 one cycle later.
  - exactly 64 each of inreg_en, xor_en-in-XOR and mem_wr_en, in LOAD/XOR/WRITE order.
  - done pulse at start+194, round_idx=1 afterwards.
- Round wrap: run 24 passes -> last_round=1 during pass 24, round_idx returns to 0 after its done, no pulse missed.
- start while busy: assert start on cycles 5 and 100 of a pass -> only one done; next pass begins only after IDLE is re-entered.
- Reset mid-pass: assert rst in WRITE of slice 30 -> IDLE next cycle, no done, round_idx=0; a new start gives a full 194-cycle pass.
- With ADDRC_CTRL_PERF_EN: one pass -> pass_cycles=193 after done; reset -> pass_cycles=0.
